// File: rtl/sw_debounce_pkg.sv
// Shared constants and types for the switch debouncer.
//   DEBOUNCE_10MS_AT_100MHZ : default stability window (10 ms at 100 MHz)
//   SIM_STABLE_CYCLES       : short window that keeps benches fast
//   edge_t                  : rise/fall pulse pair for one channel
package sw_debounce_pkg;

  localparam int DEBOUNCE_10MS_AT_100MHZ = 1000000;
  localparam int SIM_STABLE_CYCLES       = 4;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Pulse pair for a newly accepted level: exactly one of rise/fall is set.
  function automatic edge_t edge_of(input logic lvl);
    edge_t e;
    e.rise = lvl;
    e.fall = ~lvl;
    return e;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-channel conditioner: two-flop synchronizer, stability counter,
// and registered one-cycle rise/fall pulses.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous pin
//   clean      : debounced level (registered)
//   rise, fall : one-cycle pulses on accepted 0->1 / 1->0 (registered)
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter  int STABLE_CYCLES = DEBOUNCE_10MS_AT_100MHZ,
  localparam int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  generate
    if (STABLE_CYCLES < 2) begin : g_bad_param
      $error("debounce_bit: STABLE_CYCLES must be >= 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  edge_t            acc;

  assign acc = edge_of(s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == clean) begin
        // Any return to the accepted level restarts the window.
        cnt <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        // Held for STABLE_CYCLES consecutive edges: accept and pulse once.
        clean <= s2;
        cnt   <= '0;
        rise  <= acc.rise;
        fall  <= acc.fall;
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch/button conditioner: WIDTH independent debounce_bit
// channels plus an any-edge flag.
//   clk, rst_n : clock, async active-low reset
//   sw_raw     : asynchronous pins
//   sw_clean   : debounced levels
//   rise, fall : per-channel one-cycle edge pulses
//   changed    : OR of all rise/fall pulses (combinational from registers)
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter  int WIDTH         = 16,
  parameter  int STABLE_CYCLES = DEBOUNCE_10MS_AT_100MHZ,
  localparam int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_bit #(
        .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (sw_raw[i]),
        .clean(sw_clean[i]),
        .rise (rise[i]),
        .fall (fall[i])
      );
    end
  endgenerate

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam int W = 16;
  localparam int N = SIM_STABLE_CYCLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean, rise, fall;
  logic         changed;

  int tests = 0;
  int fails = 0;

  sw_debounce #(.WIDTH(W), .STABLE_CYCLES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [W-1:0] r, input logic [W-1:0] c,
                              input logic [W-1:0] ri, input logic [W-1:0] fa);
    vec_t v;
    v.raw = r; v.clean = c; v.rise = ri; v.fall = fa;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] ec,
                     input logic [W-1:0] er, input logic [W-1:0] ef);
    logic ech;
    ech = |(er | ef);
    tests++;
    if (sw_clean !== ec || rise !== er || fall !== ef || changed !== ech) begin
      fails++;
      $display("FAIL %s: got clean=%h rise=%h fall=%h changed=%b, want clean=%h rise=%h fall=%h changed=%b",
               nm, sw_clean, rise, fall, changed, ec, er, ef, ech);
    end
  endtask

  // Apply raw before the next rising edge, then sample at the falling edge.
  task automatic cyc(input logic [W-1:0] r);
    sw_raw = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic bounce [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    // Idle after reset: everything quiet.
    for (int k = 0; k < 10; k++) add(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    // Bit 0 rises, accepted on edge 6, then falls back.
    for (int k = 1; k <= 8; k++)
      add(16'h0001, (k >= 6) ? 16'h0001 : 16'h0000, (k == 6) ? 16'h0001 : 16'h0000, 16'h0000);
    for (int k = 1; k <= 6; k++)
      add(16'h0000, (k >= 6) ? 16'h0000 : 16'h0001, 16'h0000, (k == 6) ? 16'h0001 : 16'h0000);
    // Bit 3 bounce 1,1,0,1,1,1,0: never accepted.
    for (int k = 0; k < 11; k++)
      add(bounce[k] ? 16'h0008 : 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    // Bit 3 held 6 cycles: one rise at edge 6, then release falls at edge 12.
    for (int k = 1; k <= 12; k++)
      add((k <= 6) ? 16'h0008 : 16'h0000, (k >= 6 && k < 12) ? 16'h0008 : 16'h0000,
          (k == 6) ? 16'h0008 : 16'h0000, (k == 12) ? 16'h0008 : 16'h0000);
    // Eight bits together, up then down.
    for (int k = 1; k <= 6; k++)
      add(16'hA5A5, (k >= 6) ? 16'hA5A5 : 16'h0000, (k == 6) ? 16'hA5A5 : 16'h0000, 16'h0000);
    for (int k = 1; k <= 8; k++)
      add(16'h0000, (k >= 6) ? 16'h0000 : 16'hA5A5, 16'h0000, (k == 6) ? 16'hA5A5 : 16'h0000);

    // Held in reset.
    sw_raw = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("in_reset_%0d", k), 16'h0000, 16'h0000, 16'h0000);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].raw);
      chk($sformatf("vec_%0d", i), vecs[i].clean, vecs[i].rise, vecs[i].fall);
    end

    // Power-up with bit 0 high: rise once after N+2 edges.
    rst_n = 1'b0;
    sw_raw = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    chk("pwrup_reset", 16'h0000, 16'h0000, 16'h0000);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(16'h0001);
      chk($sformatf("pwrup_%0d", k), (k >= 6) ? 16'h0001 : 16'h0000,
          (k == 6) ? 16'h0001 : 16'h0000, 16'h0000);
    end

    // Reset mid-count on bit 1 while bit 0 is clean-high.
    cyc(16'h0003);
    chk("midcnt_1", 16'h0001, 16'h0000, 16'h0000);
    cyc(16'h0003);
    chk("midcnt_2", 16'h0001, 16'h0000, 16'h0000);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(16'h0003);
      chk($sformatf("after_rst_%0d", k), (k >= 6) ? 16'h0003 : 16'h0000,
          (k == 6) ? 16'h0003 : 16'h0000, 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side conditioner for board slide switches and push buttons. Raw pins enter here before any user logic; LED-driving logic sits downstream.
- Per channel it provides:
  - a two-flop synchronizer;
  - a stability-counter debouncer;
  - single-cycle rise and fall pulses.
- This gives downstream logic clean, glitch-free levels and edge events in the clk domain.

Parameters:
- WIDTH, 16, number of independent channels (one per switch).
- STABLE_CYCLES, 1000000, consecutive clk cycles a new synchronized level must hold before it is accepted (10 ms at 100 MHz). Legal range is 2 or more; elaborate-time error otherwise.
- CNT_W, $clog2(STABLE_CYCLES), counter width. Derived; not for override.

Ports:
- clk  input  1  system clock, single domain.
- rst_n  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  asynchronous switch/button pins.
- sw_clean  output  WIDTH  debounced level, registered.
- rise  output  WIDTH  one-cycle pulse when sw_clean bit goes 0->1, registered.
- fall  output  WIDTH  one-cycle pulse when sw_clean bit goes 1->0, registered.
- changed  output  1  OR-reduction of (rise | fall), combinational from registered pulses.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous, active-low. Assertion clears all state immediately, independent of clk.
- Reset values:
  - s1, s2, sw_clean, rise, fall and every counter are 0.
  - changed is 0.
- Synchronizer: per bit, s1 <= sw_raw, then s2 <= s1. Nothing downstream uses s1 or sw_raw directly.
- Per-bit counter cnt (CNT_W bits), evaluated each clk edge:
  - If s2 == sw_clean: cnt <= 0, no pulse.
  - If s2 != sw_clean and cnt != STABLE_CYCLES-1: cnt <= cnt+1, no pulse.
  - If s2 != sw_clean and cnt == STABLE_CYCLES-1:
    - sw_clean <= s2 and cnt <= 0;
    - rise <= s2, fall <= ~s2, for that one cycle only.
- Pulses: rise/fall default to 0 every cycle. They are never high for more than one cycle per transition, and never both high on the same bit.
- Latency (N = STABLE_CYCLES): if sw_raw changes and is stable before edge 1, then sw_clean and the pulse update on edge N+2, visible in cycle N+2.
- Glitch rejection: any cycle where s2 returns to sw_clean restarts the count from 0. A bounce shorter than N cycles never reaches sw_clean.
- A bit that keeps differing keeps counting. The counter never wraps; it saturates into the accept condition above.
- Channels are fully independent. Simultaneous transitions on several bits produce simultaneous pulses; changed is a single-cycle high.
- Power-up: if sw_raw bit is 1 at rst_n release, sw_clean follows after N+2 cycles and rise pulses once. This is intended; downstream treats it as a normal event.
- Reset mid-count: the count is discarded. After release, the full N+2 latency applies again.

Decomposition:
- Shared package holds:
  - the default STABLE_CYCLES constant (DEBOUNCE_10MS_AT_100MHZ = 1000000);
  - a SIM_STABLE_CYCLES = 4 constant for benches.
- One natural sub-module: debounce_bit. It is a single-channel synchronizer, counter and pulse generator with ports clk, rst_n, raw, clean, rise, fall.
- sw_debounce is a generate loop of WIDTH debounce_bit instances plus the changed OR-reduction.

Test Plan (STABLE_CYCLES=4, WIDTH=16):
- Reset with sw_raw=16'h0000, hold 10 cycles -> sw_clean=0, rise=fall=0, changed=0 every cycle.
- sw_raw[0] 0->1 before edge 1, held -> sw_clean[0]=1 from edge 6. rise[0]=1 for exactly the cycle after edge 6; fall and changed behave accordingly (changed=1 same cycle only).
- sw_raw[3] bounce: 1 for 2 cycles, 0 for 1, 1 for 3, then 0 -> sw_clean[3] stays 0 throughout, no rise/fall. Then hold 1 for 6 cycles -> exactly one rise[3] pulse.
- sw_raw 16'h0000->16'hA5A5 at once, held -> all eight bits rise in the same cycle (rise=16'hA5A5), changed=1 once. Then ->16'h0000: fall=16'hA5A5 once, N+2 cycles later.
- Release rst_n with sw_raw=16'h0001 -> sw_clean goes 16'h0001 at edge 6, one rise[0] pulse.
- Assert rst_n mid-count (sw_raw[1]=1, 2 cycles in) -> outputs 0 asynchronously. After release, sw_clean[1] rises only after a full N+2 cycles.
